// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and constants
//
// Purpose: next-PC select encoding, PC sequencer state encoding and the
//          sequential PC increment shared by the fetch-stage modules.
// Ports:   none (package).
package cpu_pkg;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_TRAP   = 2'b11
  } next_sel_e;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } pc_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - combinational redirect priority arbiter
//
// Purpose: picks the highest-priority redirect request this cycle
//          (trap > jump > branch) and its target address. Optional macro
//          PC_SEQ_ALIGN_CHECK_EN turns misaligned branch/jump targets into
//          a trap to TRAP_VECTOR.
// Ports:
//   branch_taken, branch_target  branch request and target
//   jump, jump_target            jump request and target
//   trap                         trap request
//   kind                         winning request (SEL_SEQ when none)
//   target                       winning target address
//   misalign                     winning request is a misaligned target
module pc_redirect_arb
  import cpu_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0100)
) (
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             trap,
  output next_sel_e        kind,
  output logic [WIDTH-1:0] target,
  output logic             misalign
);

  always_comb begin
    kind     = SEL_SEQ;
    target   = '0;
    misalign = 1'b0;
    if (trap) begin
      kind   = SEL_TRAP;
      target = TRAP_VECTOR;
    end else if (jump) begin
      kind   = SEL_JUMP;
      target = jump_target;
    end else if (branch_taken) begin
      kind   = SEL_BRANCH;
      target = branch_target;
    end
`ifdef PC_SEQ_ALIGN_CHECK_EN
    // A misaligned branch/jump is escalated to a trap so it also outranks
    // any later lower-priority request while it sits in the pending register.
    if ((kind == SEL_JUMP || kind == SEL_BRANCH) && target[1:0] != 2'b00) begin
      kind     = SEL_TRAP;
      target   = TRAP_VECTOR;
      misalign = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage program-counter sequencer
//
// Purpose: holds the PC, drives the 2-bit next-PC select, presents the PC
//          to instruction memory over valid/ready and latches redirects
//          that arrive while no transfer completes.
//          Optional macro PC_SEQ_ALIGN_CHECK_EN (see pc_redirect_arb).
// Ports:
//   clk, rst                      clock, async active-high reset
//   branch_taken, branch_target   branch redirect request
//   jump, jump_target             jump redirect request
//   trap                          trap request
//   pc_ready                      instruction memory accepts pc
//   pc, pc_valid                  fetch request
//   next_sel                      00 pc+4, 01 branch, 10 jump, 11 trap
//   flush                         pulse in the cycle pc takes a redirect
//   misalign                      pulse with flush when a misaligned target trapped
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             trap,
  input  logic             pc_ready,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [1:0]       next_sel,
  output logic             flush,
  output logic             misalign
);

  pc_state_e        state, state_next;

  next_sel_e        req_kind;
  logic [WIDTH-1:0] req_target;
  logic             req_mis;
  logic             req_valid;

  logic             pend_valid;
  next_sel_e        pend_kind;
  logic [WIDTH-1:0] pend_target;
  logic             pend_mis;

  next_sel_e        sel_kind;
  logic [WIDTH-1:0] sel_target;
  logic             sel_mis;
  logic             xfer;

  pc_redirect_arb #(
    .WIDTH       (WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_arb (
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .trap          (trap),
    .kind          (req_kind),
    .target        (req_target),
    .misalign      (req_mis)
  );

  assign req_valid = (req_kind != SEL_SEQ);
  assign pc_valid  = (state != BOOT);
  assign xfer      = pc_valid & pc_ready;
  assign next_sel  = sel_kind;

  // A latched redirect always takes precedence over this cycle's request.
  always_comb begin
    sel_kind   = SEL_SEQ;
    sel_target = '0;
    sel_mis    = 1'b0;
    if (pend_valid) begin
      sel_kind   = pend_kind;
      sel_target = pend_target;
      sel_mis    = pend_mis;
    end else if (req_valid) begin
      sel_kind   = req_kind;
      sel_target = req_target;
      sel_mis    = req_mis;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (!pc_ready) state_next = HOLD;
      HOLD:    if (pc_ready) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      flush       <= 1'b0;
      misalign    <= 1'b0;
      pend_valid  <= 1'b0;
      pend_kind   <= SEL_SEQ;
      pend_target <= '0;
      pend_mis    <= 1'b0;
    end else begin
      state    <= state_next;
      flush    <= 1'b0;
      misalign <= 1'b0;
      if (xfer) begin
        pc       <= (sel_kind == SEL_SEQ) ? pc + WIDTH'(PC_STEP) : sel_target;
        flush    <= (sel_kind != SEL_SEQ);
        misalign <= sel_mis;
        // When the pending redirect is consumed, a request arriving in the
        // same cycle is kept for the following transfer instead of lost.
        if (pend_valid && req_valid) begin
          pend_kind   <= req_kind;
          pend_target <= req_target;
          pend_mis    <= req_mis;
        end else begin
          pend_valid <= 1'b0;
        end
      end else if (req_valid && (!pend_valid || req_kind > pend_kind)) begin
        pend_valid  <= 1'b1;
        pend_kind   <= req_kind;
        pend_target <= req_target;
        pend_mis    <= req_mis;
      end
    end
  end

endmodule
